// File: rtl/instr_encoder_if.sv
// Field/word handshake bundle for the instruction encoder.
// Master drives triples and consumes words; slave is the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [5:0]  parameter1;
    logic [5:0]  parameter2;
    logic [15:0] IE_instruction;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_valid,
        output opcode,
        output parameter1,
        output parameter2,
        output out_ready,
        input  in_ready,
        input  IE_instruction,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  opcode,
        input  parameter1,
        input  parameter2,
        input  out_ready,
        output in_ready,
        output IE_instruction,
        output out_valid
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder / issue buffer: packs field triples into
// 16-bit words, drops illegal opcodes, queues words in a show-ahead FIFO.
module instr_encoder #(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] MAX_OPCODE = 4'd11
) (
    input  logic                     IE_clock,
    input  logic                     IE_reset,
    instr_encoder_if.slave           bus,
    input  logic                     clr_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     illegal_op,
    output logic [15:0]              issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic          accept;
    logic          legal;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [15:0]   word;

    // Handshake qualifiers; in_ready depends only on stored state.
    always_comb begin
        not_empty    = (count != '0);
        bus.in_ready = (count != FULL_CNT);
        legal        = (bus.opcode <= MAX_OPCODE);
        accept       = bus.in_valid && bus.in_ready;
        push         = accept && legal;
        pop          = not_empty && bus.out_ready;
        word         = {bus.opcode, bus.parameter1, bus.parameter2};
    end

    // Occupancy bookkeeping for simultaneous push/pop.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge IE_clock or posedge IE_reset) begin
        if (IE_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // Storage array; contents are masked at the output when empty.
    always_ff @(posedge IE_clock) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Sticky illegal-opcode flag; a new illegal accept beats a clear.
    always_ff @(posedge IE_clock or posedge IE_reset) begin
        if (IE_reset) begin
            illegal_op <= 1'b0;
        end else if (accept && !legal) begin
            illegal_op <= 1'b1;
        end else if (clr_err) begin
            illegal_op <= 1'b0;
        end
    end

    // Running count of words handed downstream, wraps at 16 bits.
    always_ff @(posedge IE_clock or posedge IE_reset) begin
        if (IE_reset) begin
            issued_count <= '0;
        end else if (pop) begin
            issued_count <= issued_count + 16'd1;
        end
    end

    // Show-ahead head presentation; zero whenever nothing is stored.
    always_comb begin
        bus.out_valid      = not_empty;
        bus.IE_instruction = not_empty ? mem[rd_ptr] : 16'h0000;
        fifo_count         = count;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder.
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        clr_err;
    logic [2:0]  fifo_count;
    logic        illegal_op;
    logic [15:0] issued_count;

    int checks;
    int errors;

    instr_encoder_if bus();

    instr_encoder #(
        .DEPTH(4),
        .MAX_OPCODE(4'd11)
    ) dut (
        .IE_clock(clk),
        .IE_reset(rst),
        .bus(bus.slave),
        .clr_err(clr_err),
        .fifo_count(fifo_count),
        .illegal_op(illegal_op),
        .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [5:0]  p1;
        logic [5:0]  p2;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic [15:0] e_ins;
        logic [2:0]  e_cnt;
        logic        e_ir;
        logic        e_ill;
        logic [15:0] e_iss;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(
        input logic iv, input logic [3:0] op,
        input logic [5:0] p1, input logic [5:0] p2,
        input logic ordy, input logic clr,
        input logic e_ov, input logic [15:0] e_ins,
        input logic [2:0] e_cnt, input logic e_ir,
        input logic e_ill, input logic [15:0] e_iss);
        vec_t v;
        v.iv = iv; v.op = op; v.p1 = p1; v.p2 = p2;
        v.ordy = ordy; v.clr = clr;
        v.e_ov = e_ov; v.e_ins = e_ins; v.e_cnt = e_cnt;
        v.e_ir = e_ir; v.e_ill = e_ill; v.e_iss = e_iss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] op,
                         input logic [5:0] p1, input logic [5:0] p2,
                         input logic ordy, input logic clr);
        bus.in_valid   = iv;
        bus.opcode     = op;
        bus.parameter1 = p1;
        bus.parameter2 = p2;
        bus.out_ready  = ordy;
        clr_err        = clr;
    endtask

    logic [15:0] expq[$];
    logic [15:0] w;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 1'b0);

        // index: iv op p1 p2 ordy clr | ov ins cnt ir ill iss
        vt[0]  = mk(1, 4'd1, 6'd1,  6'd1,  1, 0, 1, 16'h1041, 3'd1, 1, 0, 16'd1 - 16'd1);
        vt[1]  = mk(0, 4'd0, 6'd0,  6'd0,  1, 0, 0, 16'h0000, 3'd0, 1, 0, 16'd1);
        vt[2]  = mk(1, 4'd2, 6'd12, 6'd51, 0, 0, 1, 16'h2333, 3'd1, 1, 0, 16'd1);
        vt[3]  = mk(1, 4'd3, 6'd0,  6'd1,  0, 0, 1, 16'h2333, 3'd2, 1, 0, 16'd1);
        vt[4]  = mk(1, 4'd4, 6'd2,  6'd0,  0, 0, 1, 16'h2333, 3'd3, 1, 0, 16'd1);
        vt[5]  = mk(1, 4'd5, 6'd63, 6'd63, 0, 0, 1, 16'h2333, 3'd4, 0, 0, 16'd1);
        vt[6]  = mk(1, 4'd6, 6'd0,  6'd0,  0, 0, 1, 16'h2333, 3'd4, 0, 0, 16'd1);
        vt[7]  = mk(1, 4'd6, 6'd0,  6'd0,  1, 0, 1, 16'h3001, 3'd3, 1, 0, 16'd2);
        vt[8]  = mk(0, 4'd0, 6'd0,  6'd0,  1, 0, 1, 16'h4080, 3'd2, 1, 0, 16'd3);
        vt[9]  = mk(0, 4'd0, 6'd0,  6'd0,  1, 0, 1, 16'h5FFF, 3'd1, 1, 0, 16'd4);
        vt[10] = mk(0, 4'd0, 6'd0,  6'd0,  1, 0, 0, 16'h0000, 3'd0, 1, 0, 16'd5);
        vt[11] = mk(0, 4'd0, 6'd0,  6'd0,  1, 0, 0, 16'h0000, 3'd0, 1, 0, 16'd5);
        vt[12] = mk(1, 4'hF, 6'd5,  6'd5,  0, 0, 0, 16'h0000, 3'd0, 1, 1, 16'd5);
        vt[13] = mk(1, 4'hC, 6'd1,  6'd1,  0, 1, 0, 16'h0000, 3'd0, 1, 1, 16'd5);
        vt[14] = mk(0, 4'd0, 6'd0,  6'd0,  0, 1, 0, 16'h0000, 3'd0, 1, 0, 16'd5);
        vt[15] = mk(1, 4'hB, 6'd1,  6'd2,  0, 0, 1, 16'hB042, 3'd1, 1, 0, 16'd5);
        vt[16] = mk(1, 4'hD, 6'd0,  6'd0,  1, 0, 0, 16'h0000, 3'd0, 1, 1, 16'd6);
        vt[17] = mk(0, 4'd0, 6'd0,  6'd0,  0, 1, 0, 16'h0000, 3'd0, 1, 0, 16'd6);

        // reset state
        @(negedge clk);
        chk("rst_ov", 16'(bus.out_valid), 16'd0);
        chk("rst_ins", bus.IE_instruction, 16'h0000);
        chk("rst_cnt", 16'(fifo_count), 16'd0);
        chk("rst_ill", 16'(illegal_op), 16'd0);
        chk("rst_iss", issued_count, 16'd0);
        chk("rst_ir", 16'(bus.in_ready), 16'd1);
        rst = 1'b0;

        // table: inputs applied at a negedge, results checked one cycle later
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].iv, vt[i].op, vt[i].p1, vt[i].p2,
                  vt[i].ordy, vt[i].clr);
            @(negedge clk);
            chk($sformatf("v%0d_ov", i), 16'(bus.out_valid), 16'(vt[i].e_ov));
            chk($sformatf("v%0d_ins", i), bus.IE_instruction, vt[i].e_ins);
            chk($sformatf("v%0d_cnt", i), 16'(fifo_count), 16'(vt[i].e_cnt));
            chk($sformatf("v%0d_ir", i), 16'(bus.in_ready), 16'(vt[i].e_ir));
            chk($sformatf("v%0d_ill", i), 16'(illegal_op), 16'(vt[i].e_ill));
            chk($sformatf("v%0d_iss", i), issued_count, vt[i].e_iss);
        end

        // simultaneous push and pop with two words stored
        drive(1'b1, 4'd7, 6'd1, 6'd1, 1'b0, 1'b0);
        expq.push_back(16'h7041);
        @(negedge clk);
        drive(1'b1, 4'd8, 6'd2, 6'd2, 1'b0, 1'b0);
        expq.push_back(16'h8082);
        @(negedge clk);
        chk("pp_cnt0", 16'(fifo_count), 16'd2);
        for (int i = 0; i < 6; i++) begin
            w = {4'(i + 1), 6'(i), 6'(2 * i)};
            drive(1'b1, 4'(i + 1), 6'(i), 6'(2 * i), 1'b1, 1'b0);
            chk($sformatf("pp_head%0d", i), bus.IE_instruction, expq[0]);
            void'(expq.pop_front());
            expq.push_back(w);
            @(negedge clk);
            chk($sformatf("pp_cnt%0d", i + 1), 16'(fifo_count), 16'd2);
        end
        chk("pp_iss", issued_count, 16'd12);
        chk("pp_tail_head", bus.IE_instruction, expq[0]);

        // async reset with three words stored and the error flag set
        drive(1'b1, 4'd9, 6'd9, 6'd9, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'hE, 6'd0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_cnt", 16'(fifo_count), 16'd3);
        chk("pre_rst_ill", 16'(illegal_op), 16'd1);
        drive(1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ov", 16'(bus.out_valid), 16'd0);
        chk("arst_ins", bus.IE_instruction, 16'h0000);
        chk("arst_cnt", 16'(fifo_count), 16'd0);
        chk("arst_ill", 16'(illegal_op), 16'd0);
        chk("arst_iss", issued_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'd9, 6'd4, 6'd35, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_head", bus.IE_instruction, 16'h9123);
        chk("post_rst_cnt", 16'(fifo_count), 16'd1);

        // issued_count wrap: one pop per cycle with a refilling push
        drive(1'b1, 4'd1, 6'd0, 6'd0, 1'b1, 1'b0);
        repeat (65534) @(negedge clk);
        chk("wrap_fffe", issued_count, 16'hFFFE);
        chk("wrap_cnt", 16'(fifo_count), 16'd1);
        @(negedge clk);
        chk("wrap_ffff", issued_count, 16'hFFFF);
        @(negedge clk);
        chk("wrap_0000", issued_count, 16'h0000);
        drive(1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
